xbox_mem_arb: RTL

- Arbitrates NUM_XLRS accelerator requesters onto the per-instance accelerator port of the XBOX memory farm.
- Performs round-robin arbitration independently per memory instance.
- Supports locked bursts with a forced-release limit, and returns read data one cycle after grant.
- Sits between the accelerator engines and the farm's xlr_mem_* interface; SoC/TCM access remains subordinate to any granted accelerator access, as the farm defines.

---
 rtl/xbox_mem_arb.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/xbox_mem_arb.sv
// Accelerator-side arbiter for the XBOX memory farm: one round-robin arbiter per
// memory instance with locked bursts, forced release, and one-cycle read return.

module xbox_mem_arb_inst #(
  parameter int NUM_XLRS = 4,
  parameter int AW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_XLRS-1:0]           elig,
  input  logic [NUM_XLRS-1:0]           lock,
  input  logic [NUM_XLRS-1:0]           wr,
  input  logic [NUM_XLRS-1:0][AW-1:0]   addr,
  input  logic [NUM_XLRS-1:0][255:0]    wdata,
  input  logic [NUM_XLRS-1:0][31:0]     be,
  output logic [NUM_XLRS-1:0]           grant,
  output logic [AW-1:0]                 mem_addr,
  output logic [255:0]                  mem_wdata,
  output logic [31:0]                   mem_be,
  output logic                          mem_rd,
  output logic                          mem_wr
);
  localparam int XW = $clog2(NUM_XLRS);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    st;
  logic [XW-1:0] rr_ptr, owner, win;
  logic [CW-1:0] cnt;
  logic          win_vld;

  function automatic logic [XW-1:0] wrap(input int v);
    return XW'(v >= NUM_XLRS ? v - NUM_XLRS : v);
  endfunction

  // descending scan so the last hit is the first eligible index from rr_ptr
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    if (st == LOCKED) begin
      win     = owner;
      win_vld = elig[owner];
    end else begin
      for (int i = NUM_XLRS - 1; i >= 0; i--) begin
        if (elig[wrap(int'(rr_ptr) + i)]) begin
          win     = wrap(int'(rr_ptr) + i);
          win_vld = 1'b1;
        end
      end
    end
    win_vld = win_vld & rst_n;
  end

  always_comb begin
    grant     = win_vld ? (NUM_XLRS'(1) << win) : '0;
    mem_rd    = win_vld & ~wr[win];
    mem_wr    = win_vld & wr[win];
    mem_addr  = win_vld ? addr[win]  : '0;
    mem_wdata = win_vld ? wdata[win] : '0;
    mem_be    = win_vld ? be[win]    : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
    end else begin
      case (st)
        IDLE: if (win_vld) begin
          if (lock[win]) begin
            st    <= LOCKED;
            owner <= win;
            cnt   <= '0;
          end else begin
            rr_ptr <= wrap(int'(win) + 1);
          end
        end
        LOCKED: begin
          // the beat granted in the releasing cycle still goes to the farm
          if ((win_vld && !lock[owner]) || cnt == CW'(MAX_HOLD - 1)) begin
            st     <= IDLE;
            rr_ptr <= wrap(int'(owner) + 1);
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

module xbox_mem_arb #(
  parameter int NUM_MEMS           = 2,
  parameter int NUM_XLRS           = 4,
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int MAX_HOLD           = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_XLRS-1:0]                           req_valid,
  input  logic [NUM_XLRS-1:0][3:0]                      req_mem_sel,
  input  logic [NUM_XLRS-1:0]                           req_wr,
  input  logic [NUM_XLRS-1:0][LOG2_LINES_PER_MEM-1:0]   req_addr,
  input  logic [NUM_XLRS-1:0][255:0]                    req_wdata,
  input  logic [NUM_XLRS-1:0][31:0]                     req_be,
  input  logic [NUM_XLRS-1:0]                           req_lock,
  output logic [NUM_XLRS-1:0]                           req_ready,
  output logic [NUM_XLRS-1:0]                           rsp_valid,
  output logic [NUM_XLRS-1:0][255:0]                    rsp_rdata,
  output logic [NUM_XLRS-1:0]                           err_oor,
  output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
  output logic [NUM_MEMS-1:0][255:0]                    xlr_mem_wdata,
  output logic [NUM_MEMS-1:0][31:0]                     xlr_mem_be,
  output logic [NUM_MEMS-1:0]                           xlr_mem_rd,
  output logic [NUM_MEMS-1:0]                           xlr_mem_wr,
  input  logic [NUM_MEMS-1:0][255:0]                    xlr_mem_rdata
);
  logic [NUM_MEMS-1:0][NUM_XLRS-1:0] elig, grant;
  logic [NUM_XLRS-1:0]               oor, rsp_vld_q;
  logic [NUM_XLRS-1:0][3:0]          mem_q;

  for (genvar r = 0; r < NUM_XLRS; r++) begin : g_oor
    assign oor[r] = req_valid[r] && ({1'b0, req_mem_sel[r]} >= 5'(NUM_MEMS));
  end

  for (genvar m = 0; m < NUM_MEMS; m++) begin : g_mem
    for (genvar r = 0; r < NUM_XLRS; r++) begin : g_elig
      assign elig[m][r] = req_valid[r] && (req_mem_sel[r] == 4'(m));
    end
    xbox_mem_arb_inst #(
      .NUM_XLRS (NUM_XLRS),
      .AW       (LOG2_LINES_PER_MEM),
      .MAX_HOLD (MAX_HOLD)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .elig      (elig[m]),
      .lock      (req_lock),
      .wr        (req_wr),
      .addr      (req_addr),
      .wdata     (req_wdata),
      .be        (req_be),
      .grant     (grant[m]),
      .mem_addr  (xlr_mem_addr[m]),
      .mem_wdata (xlr_mem_wdata[m]),
      .mem_be    (xlr_mem_be[m]),
      .mem_rd    (xlr_mem_rd[m]),
      .mem_wr    (xlr_mem_wr[m])
    );
  end

  // out-of-range requests are absorbed immediately so they never stall a requester
  always_comb begin
    req_ready = oor & {NUM_XLRS{rst_n}};
    for (int m = 0; m < NUM_MEMS; m++) req_ready = req_ready | grant[m];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= '0;
      mem_q     <= '0;
      err_oor   <= '0;
    end else begin
      rsp_vld_q <= req_ready & ~req_wr;
      mem_q     <= req_mem_sel;
      err_oor   <= err_oor | oor;
    end
  end

  // an out-of-range mem_q matches no instance, so its response data stays zero
  always_comb begin
    rsp_rdata = '0;
    for (int r = 0; r < NUM_XLRS; r++)
      for (int m = 0; m < NUM_MEMS; m++)
        if (rsp_vld_q[r] && mem_q[r] == 4'(m)) rsp_rdata[r] = xlr_mem_rdata[m];
  end

  assign rsp_valid = rsp_vld_q;
endmodule
